// File: rtl/riscv_core_pkg.sv
// Shared core types and widths used by the writeback arbitration slice.
package riscv_core_pkg;

   localparam int XLEN   = 64;
   localparam int REG_AW = 5;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   wd;
   } wb_entry_t;

endpackage

// File: rtl/riscv_core_wb_fifo.sv
// Synchronous FIFO holding multi-cycle results until they win the register-file write port.
module riscv_core_wb_fifo
   import riscv_core_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  wb_entry_t push_data,
   input  logic      pop,
   output wb_entry_t head,
   output logic      full,
   output logic      empty
);

   localparam int AW = $clog2(DEPTH);

   wb_entry_t     mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [AW:0]   count_n;
   logic          do_push;
   logic          do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign count_n = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Flags are registered from the next count so consumers see them straight from flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count_n;
         full  <= (count_n == (AW+1)'(DEPTH));
         empty <= (count_n == '0);
      end
   end

endmodule

// File: rtl/riscv_core_wb_arb.sv
// Writeback arbiter: shares the register-file write port between the pipeline and buffered
// mul/div results, with starvation-forced drains and a pending-result scoreboard.
module riscv_core_wb_arb
   import riscv_core_pkg::*;
#(
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              i_wb_clk,
   input  logic              i_wb_rst,
   input  logic              i_wb_pipe_we,
   input  logic [REG_AW-1:0] i_wb_pipe_rd,
   input  logic [XLEN-1:0]   i_wb_pipe_wd,
   input  logic              i_wb_ml_valid,
   input  logic [REG_AW-1:0] i_wb_ml_rd,
   input  logic [XLEN-1:0]   i_wb_ml_wd,
   output logic              o_wb_ml_ready,
   input  logic              i_wb_issue,
   input  logic [REG_AW-1:0] i_wb_issue_rd,
   output logic [31:0]       o_wb_busy,
   output logic              o_wb_stall,
   output logic              o_wb_rf_we3,
   output logic [REG_AW-1:0] o_wb_rf_a3,
   output logic [XLEN-1:0]   o_wb_rf_wd3
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   wb_entry_t     ml_entry;
   wb_entry_t     head;
   logic          fifo_push;
   logic          fifo_full;
   logic          fifo_empty;
   logic          pipe_eff;
   logic          force_drain;
   logic          head_grant;
   logic          pipe_grant;
   logic [CW-1:0] starve_q;
   logic [31:0]   busy_q;
   logic [31:0]   busy_n;

   assign pipe_eff      = i_wb_pipe_we && (i_wb_pipe_rd != '0);
   assign o_wb_ml_ready = !fifo_full;
   assign fifo_push     = i_wb_ml_valid && !fifo_full && (i_wb_ml_rd != '0);
   assign ml_entry.rd   = i_wb_ml_rd;
   assign ml_entry.wd   = i_wb_ml_wd;

   riscv_core_wb_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk      (i_wb_clk),
      .rst      (i_wb_rst),
      .push     (fifo_push),
      .push_data(ml_entry),
      .pop      (head_grant),
      .head     (head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // The pipeline owns the port unless the buffered head has waited STARVE_LIMIT cycles.
   assign force_drain = !i_wb_rst && !fifo_empty && (starve_q == LIMIT);
   assign head_grant  = !i_wb_rst && !fifo_empty && (force_drain || !pipe_eff);
   assign pipe_grant  = !i_wb_rst && pipe_eff && !force_drain;
   assign o_wb_stall  = force_drain;
   assign o_wb_rf_we3 = head_grant || pipe_grant;
   assign o_wb_rf_a3  = head_grant ? head.rd : i_wb_pipe_rd;
   assign o_wb_rf_wd3 = head_grant ? head.wd : i_wb_pipe_wd;

   always_ff @(posedge i_wb_clk) begin
      if (i_wb_rst) begin
         starve_q <= '0;
      end else if (fifo_empty || head_grant) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_q + CW'(1);
      end
   end

   // Set is applied after clear so a re-issue to the register being retired keeps it busy.
   always_comb begin
      busy_n = busy_q;
      if (head_grant) begin
         busy_n[head.rd] = 1'b0;
      end
      if (i_wb_issue && (i_wb_issue_rd != '0)) begin
         busy_n[i_wb_issue_rd] = 1'b1;
      end
      busy_n[0] = 1'b0;
   end

   always_ff @(posedge i_wb_clk) begin
      if (i_wb_rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_n;
      end
   end

   assign o_wb_busy = busy_q;

   a_issue_not_busy: assert property (@(posedge i_wb_clk) disable iff (i_wb_rst)
      (i_wb_issue && (i_wb_issue_rd != '0)) |->
         (!busy_q[i_wb_issue_rd] || (head_grant && (head.rd == i_wb_issue_rd))));

   a_pipe_not_busy: assert property (@(posedge i_wb_clk) disable iff (i_wb_rst)
      pipe_eff |-> !busy_q[i_wb_pipe_rd]);

endmodule

// File: tb/tb_riscv_core_wb_arb.sv
// Directed bench: stimulus pushes expected RF writes into a queue, a negedge monitor pops and compares.
module tb_riscv_core_wb_arb;
   import riscv_core_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_we;
   logic [4:0]  pipe_rd;
   logic [63:0] pipe_wd;
   logic        ml_valid;
   logic [4:0]  ml_rd;
   logic [63:0] ml_wd;
   logic        ml_ready;
   logic        issue;
   logic [4:0]  issue_rd;
   logic [31:0] busy;
   logic        stall;
   logic        we3;
   logic [4:0]  a3;
   logic [63:0] wd3;

   int checks = 0;
   int errors = 0;
   wb_entry_t exp_q[$];

   riscv_core_wb_arb #(
      .FIFO_DEPTH  (2),
      .STARVE_LIMIT(8)
   ) dut (
      .i_wb_clk     (clk),
      .i_wb_rst     (rst),
      .i_wb_pipe_we (pipe_we),
      .i_wb_pipe_rd (pipe_rd),
      .i_wb_pipe_wd (pipe_wd),
      .i_wb_ml_valid(ml_valid),
      .i_wb_ml_rd   (ml_rd),
      .i_wb_ml_wd   (ml_wd),
      .o_wb_ml_ready(ml_ready),
      .i_wb_issue   (issue),
      .i_wb_issue_rd(issue_rd),
      .o_wb_busy    (busy),
      .o_wb_stall   (stall),
      .o_wb_rf_we3  (we3),
      .o_wb_rf_a3   (a3),
      .o_wb_rf_wd3  (wd3)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog got timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   always @(negedge clk) begin
      wb_entry_t e;
      if (we3) begin
         checks++;
         if (rst) begin
            errors++;
            $display("[TB] FAIL rf_write_in_reset got a3=%0d wd3=%h required no write", a3, wd3);
         end else if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL rf_write_unexpected got a3=%0d wd3=%h required no write", a3, wd3);
         end else begin
            e = exp_q.pop_front();
            if ((a3 !== e.rd) || (wd3 !== e.wd)) begin
               errors++;
               $display("[TB] FAIL rf_write got a3=%0d wd3=%h required a3=%0d wd3=%h",
                        a3, wd3, e.rd, e.wd);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      pipe_we  = 1'b0;
      pipe_rd  = '0;
      pipe_wd  = '0;
      ml_valid = 1'b0;
      ml_rd    = '0;
      ml_wd    = '0;
      issue    = 1'b0;
      issue_rd = '0;
   endtask

   task automatic push_exp(input logic [4:0] rd, input logic [63:0] wd);
      wb_entry_t e;
      e.rd = rd;
      e.wd = wd;
      exp_q.push_back(e);
   endtask

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %h required %h", name, act, exp);
      end
   endtask

   initial begin
      set_idle();
      rst      = 1'b1;
      pipe_we  = 1'b1;
      pipe_rd  = 5'd3;
      pipe_wd  = 64'h55;
      ml_valid = 1'b1;
      ml_rd    = 5'd9;
      ml_wd    = 64'h1;
      cyc();
      #1;
      check_output("reset_we3", 64'(we3), 64'd0);
      check_output("reset_stall", 64'(stall), 64'd0);
      cyc();
      cyc();
      rst = 1'b0;
      set_idle();
      #1;
      check_output("post_reset_busy", 64'(busy), 64'd0);
      check_output("post_reset_ready", 64'(ml_ready), 64'd1);
      check_output("post_reset_we3", 64'(we3), 64'd0);

      // single multi-cycle result on an idle pipe
      cyc();
      issue = 1'b1; issue_rd = 5'd5;
      cyc();
      issue = 1'b0; ml_valid = 1'b1; ml_rd = 5'd5; ml_wd = 64'hDEAD;
      #1;
      check_output("issue_sets_busy5", 64'(busy[5]), 64'd1);
      check_output("idle_ready", 64'(ml_ready), 64'd1);
      check_output("no_bypass_we3", 64'(we3), 64'd0);
      cyc();
      ml_valid = 1'b0;
      push_exp(5'd5, 64'hDEAD);
      #1;
      check_output("head_write_we3", 64'(we3), 64'd1);
      check_output("busy5_until_write", 64'(busy[5]), 64'd1);
      cyc();
      #1;
      check_output("busy5_cleared", 64'(busy), 64'd0);

      // x0 writes from both sources are ignored
      cyc();
      ml_valid = 1'b1; ml_rd = 5'd0; ml_wd = 64'hBAD;
      pipe_we  = 1'b1; pipe_rd = 5'd0; pipe_wd = 64'hBAD2;
      #1;
      check_output("x0_we3", 64'(we3), 64'd0);
      check_output("x0_ready", 64'(ml_ready), 64'd1);
      cyc();
      set_idle();
      #1;
      check_output("x0_no_occupancy", 64'(we3), 64'd0);
      check_output("x0_busy", 64'(busy), 64'd0);

      // starvation: pipe writes x1 every cycle while x7 waits in the buffer
      cyc();
      issue = 1'b1; issue_rd = 5'd7;
      cyc();
      issue = 1'b0;
      ml_valid = 1'b1; ml_rd = 5'd7; ml_wd = 64'h77;
      pipe_we = 1'b1; pipe_rd = 5'd1; pipe_wd = 64'd100;
      push_exp(5'd1, 64'd100);
      #1;
      check_output("starve_accept_ready", 64'(ml_ready), 64'd1);
      check_output("starve_stall_c0", 64'(stall), 64'd0);
      for (int i = 1; i <= 8; i++) begin
         cyc();
         ml_valid = 1'b0;
         pipe_wd = 64'(100 + i);
         push_exp(5'd1, 64'(100 + i));
         #1;
         check_output($sformatf("starve_no_stall_%0d", i), 64'(stall), 64'd0);
      end
      cyc();
      pipe_wd = 64'd109;
      push_exp(5'd7, 64'h77);
      #1;
      check_output("starve_stall", 64'(stall), 64'd1);
      check_output("starve_head_a3", 64'(a3), 64'd7);
      cyc();
      pipe_wd = 64'd109;
      push_exp(5'd1, 64'd109);
      #1;
      check_output("starve_stall_cleared", 64'(stall), 64'd0);
      check_output("starve_busy7", 64'(busy[7]), 64'd0);
      cyc();
      set_idle();
      #1;
      check_output("starve_busy_all", 64'(busy), 64'd0);

      // back-to-back results fill the buffer while the pipe holds the port
      cyc();
      issue = 1'b1; issue_rd = 5'd10;
      cyc();
      issue_rd = 5'd11;
      cyc();
      issue_rd = 5'd12;
      cyc();
      issue = 1'b0;
      pipe_we = 1'b1; pipe_rd = 5'd2; pipe_wd = 64'd200;
      ml_valid = 1'b1; ml_rd = 5'd10; ml_wd = 64'hA0;
      push_exp(5'd2, 64'd200);
      #1;
      check_output("fill_ready_0", 64'(ml_ready), 64'd1);
      cyc();
      pipe_wd = 64'd201; ml_rd = 5'd11; ml_wd = 64'hA1;
      push_exp(5'd2, 64'd201);
      #1;
      check_output("fill_ready_1", 64'(ml_ready), 64'd1);
      cyc();
      pipe_wd = 64'd202; ml_rd = 5'd12; ml_wd = 64'hA2;
      push_exp(5'd2, 64'd202);
      #1;
      check_output("full_ready", 64'(ml_ready), 64'd0);
      cyc();
      pipe_we = 1'b0;
      push_exp(5'd10, 64'hA0);
      #1;
      check_output("full_drain_ready", 64'(ml_ready), 64'd0);
      cyc();
      push_exp(5'd11, 64'hA1);
      #1;
      check_output("slot_freed_ready", 64'(ml_ready), 64'd1);
      cyc();
      ml_valid = 1'b0;
      push_exp(5'd12, 64'hA2);
      cyc();
      #1;
      check_output("fill_busy_all", 64'(busy), 64'd0);

      // re-issue of x3 in the cycle its buffered result retires
      cyc();
      issue = 1'b1; issue_rd = 5'd3;
      cyc();
      issue = 1'b0;
      ml_valid = 1'b1; ml_rd = 5'd3; ml_wd = 64'h33;
      cyc();
      ml_valid = 1'b0;
      issue = 1'b1; issue_rd = 5'd3;
      push_exp(5'd3, 64'h33);
      cyc();
      issue = 1'b0;
      ml_valid = 1'b1; ml_rd = 5'd3; ml_wd = 64'h34;
      #1;
      check_output("set_wins_busy3", 64'(busy[3]), 64'd1);
      cyc();
      ml_valid = 1'b0;
      push_exp(5'd3, 64'h34);
      cyc();
      #1;
      check_output("set_wins_cleanup", 64'(busy), 64'd0);

      // reset with two buffered entries
      cyc();
      issue = 1'b1; issue_rd = 5'd20;
      cyc();
      issue_rd = 5'd21;
      cyc();
      issue = 1'b0;
      pipe_we = 1'b1; pipe_rd = 5'd4; pipe_wd = 64'd300;
      ml_valid = 1'b1; ml_rd = 5'd20; ml_wd = 64'hB0;
      push_exp(5'd4, 64'd300);
      cyc();
      pipe_wd = 64'd301; ml_rd = 5'd21; ml_wd = 64'hB1;
      push_exp(5'd4, 64'd301);
      cyc();
      rst = 1'b1;
      ml_valid = 1'b0;
      pipe_wd = 64'd302;
      #1;
      check_output("midreset_we3", 64'(we3), 64'd0);
      check_output("midreset_stall", 64'(stall), 64'd0);
      cyc();
      cyc();
      rst = 1'b0;
      set_idle();
      #1;
      check_output("midreset_busy", 64'(busy), 64'd0);
      check_output("midreset_ready", 64'(ml_ready), 64'd1);
      check_output("midreset_no_stale", 64'(we3), 64'd0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         #1;
         check_output($sformatf("midreset_no_stale_%0d", i), 64'(we3), 64'd0);
      end

      cyc();
      check_output("exp_queue_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/riscv_core_wb_arb.md
RISCV_CORE_WB_ARB -- requirements
Module: riscv_core_wb_arb

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, multi-cycle result buffer entries (power of two, >=2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, consecutive denied cycles before a forced buffer drain.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 i_wb_clk  in  1  rising-edge clock.
REQ-005 i_wb_rst  in  1  synchronous active-high reset.
REQ-006 i_wb_pipe_we  in  1  pipeline writeback valid.
REQ-007 i_wb_pipe_rd  in  5  pipeline destination register.
REQ-008 i_wb_pipe_wd  in  64  pipeline write data.
REQ-009 i_wb_ml_valid  in  1  multi-cycle (mul/div) result valid.
REQ-010 i_wb_ml_rd  in  5  multi-cycle destination register.
REQ-011 i_wb_ml_wd  in  64  multi-cycle result data.
REQ-012 o_wb_ml_ready  out  1  result accepted when valid&&ready.
REQ-013 i_wb_issue  in  1  multi-cycle op issued this cycle.
REQ-014 i_wb_issue_rd  in  5  destination of the issued op.
REQ-015 o_wb_busy  out  32  scoreboard, bit n = xn has a pending multi-cycle result.
REQ-016 o_wb_stall  out  1  pipeline writeback denied this cycle; upstream holds it.
REQ-017 o_wb_rf_we3 / o_wb_rf_a3 / o_wb_rf_wd3  out  1/5/64  register-file write port.

Function
REQ-018 Effective pipe write = i_wb_pipe_we && i_wb_pipe_rd!=0; rd==0 pipe writes never occupy the port.
REQ-019 Default grant: the effective pipe write drives the RF port combinationally in the same cycle.
REQ-020 Buffer head SHALL drive the RF port in any cycle with no effective pipe write and no forced drain.
REQ-021 o_wb_ml_ready = !full; results are enqueued on the valid&&ready edge; rd==0 results are accepted and discarded.
REQ-022 Full buffer: ready is 0 even if the head drains that cycle (no same-cycle free-slot reuse).
REQ-023 Enqueue-to-RF latency: 1 cycle minimum; no combinational bypass from ml inputs to the RF port.
REQ-024 Starve counter: increments each cycle the buffer is non-empty and the head is denied; clears on a head write or when empty.
REQ-025 When counter == STARVE_LIMIT: o_wb_stall=1, head granted, pipe write blocked; upstream repeats it next cycle; counter clears.
REQ-026 o_wb_stall SHALL be 0 in all other cycles.
REQ-027 o_wb_rf_we3=0 whenever neither source is granted; a3 and wd3 are don't-care then.
REQ-028 Scoreboard: busy[issue_rd] set on i_wb_issue with rd!=0; busy[rd] cleared when that rd's buffered result is written.
REQ-029 Same-cycle set and clear of one register: set wins.
REQ-030 busy[0] SHALL be constant 0.
REQ-031 Issue to an already-busy rd, or a pipe write to a busy rd, is illegal upstream; assertion only, no recovery.
REQ-032 Buffer order is strict FIFO; no reordering across register numbers.

Reset
REQ-033 On i_wb_rst: buffer empty, starve counter 0, o_wb_busy=0, o_wb_ml_ready=1 from the next cycle.
REQ-034 During reset: o_wb_rf_we3=0 and o_wb_stall=0 regardless of inputs.
REQ-035 Reset mid-operation discards buffered results and pending busy bits without issuing RF writes.

Structure
REQ-036 Shared package riscv_core_pkg SHALL hold XLEN=64, REG_AW=5, and wb_entry_t {rd, wd}.
REQ-037 Buffer SHALL be sub-module riscv_core_wb_fifo (sync, registered outputs, full/empty flags); arbitration, starve logic and scoreboard stay in the top module.

Verification
REQ-038 Idle pipe; issue x5, then ml result x5=0xDEAD -> next cycle we3=1, a3=5, wd3=0xDEAD; busy[5] 1->0.
REQ-039 Pipe writes x1 every cycle; one ml result x7 -> stall=1 exactly on the 9th denied cycle, x7 written then, pipe write repeated next cycle.
REQ-040 Three ml results back-to-back with pipe busy -> ready drops after 2 accepts; third held until a slot frees; RF order preserved.
REQ-041 Issue x3 in the same cycle the buffered x3 result writes -> busy[3] remains 1.
REQ-042 ml result to x0 and pipe write to x0 -> no RF write, no buffer occupancy, busy unchanged.
REQ-043 Reset asserted with 2 buffered entries -> we3=0, busy=0, and no stale write after reset release.
